sync_fifo_v2: RTL and testbench
===============================

# sync_fifo_v2

Parametrised single-clock FIFO, successor to the fixed 16×8 synchronous FIFO. Adds configurable almost-full/almost-empty thresholds, an occupancy count output, a synchronous flush, and an optional first-word-fall-through read mode. It sits between a producer and a consumer in the same clock domain and keeps the existing handshake and status semantics (wr_ack, overflow, underflow, full/empty/almost flags).

## Interface
- DATA_WIDTH, 16, width of each stored word
- DEPTH, 8, number of entries; power of two, ≥ 4
- AF_THRESH, DEPTH-1, almostfull asserts when count ≥ AF_THRESH (1 ≤ AF_THRESH < DEPTH)
- AE_THRESH, 1, almostempty asserts when count ≤ AE_THRESH (0 < AE_THRESH < DEPTH)

- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous flush
- wr_en  input  1  write request
- data_in  input  DATA_WIDTH  write data
- rd_en  input  1  read request
- data_out  output  DATA_WIDTH  read data
- wr_ack  output  1  registered: the previous cycle's write was accepted
- overflow  output  1  registered: the previous cycle's write was rejected (full)
- underflow  output  1  registered: the previous cycle's read was rejected (empty)
- full, empty, almostfull, almostempty  output  1  status flags, decoded from count
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH×DATA_WIDTH array. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a separate register.
- Write accept: wr_acc = wr_en & !full & !clr. Read accept: rd_acc = rd_en & !empty & !clr. Both use full/empty as they stand at the start of the cycle.
- Simultaneous wr+rd:
  - Not full and not empty: both accepted, count unchanged.
  - Full: the read is accepted and the write is rejected (overflow); count becomes DEPTH-1.
  - Empty: the write is accepted and the read is rejected (underflow); count becomes 1.
- count_next = count + wr_acc − rd_acc.
- Flags:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almostfull = (count ≥ AF_THRESH)
  - almostempty = (count ≤ AE_THRESH)
  - Flags are combinational from the count register. almostfull is high while full, and almostempty is high while empty.
- Response registers, set on the clock edge:
  - wr_ack ← wr_acc
  - overflow ← wr_en & full & !clr
  - underflow ← rd_en & empty & !clr
- clr has priority over wr_en and rd_en. On the clock edge it zeroes pointers and count and clears wr_ack, overflow and underflow. Memory contents are not cleared.
- Standard-mode data_out: registered. It loads mem[rd_ptr] on rd_acc and otherwise holds. clr does not change it.

## Timing
- Reset (rst_n low, asynchronous): pointers, count, wr_ack, overflow, underflow and data_out all go to 0. Hence empty=1, almostempty=1, full=0, almostfull=0.
- Reset asserted mid-operation discards all contents immediately. The first edge after deassertion behaves as for an empty FIFO.
- Write latency: data written at edge N is readable from edge N onward. count, flags and wr_ack update at edge N.
- Read latency (standard mode): rd_acc sampled at edge N gives valid data_out after edge N, i.e. 1 cycle.
- overflow and underflow are single-cycle pulses per rejected request. Repeated requests give repeated pulses.

## Configuration
- SYNC_FIFO_FWFT_EN
  - Undefined: standard mode as described above.
  - Defined: first-word-fall-through mode. data_out = empty ? 0 : mem[rd_ptr], combinationally. The head word is visible in the same cycle that empty falls. rd_en pops the head, and the next word (or 0 if the FIFO becomes empty) appears after that edge.
  - All flags, count, wr_ack, overflow, underflow and clr behave identically in both modes. In FWFT mode data_out is 0 during reset.

## Test plan
- Reset, then write 0x0001..0x0008 on consecutive cycles (DEPTH=8) → wr_ack high for 8 cycles. count steps 1..8. almostfull rises when count=7. full=1 at count=8.
- While full, wr_en=1, data_in=0xBEEF → overflow=1 for one cycle, wr_ack=0, count stays 8. A later read returns 0x0001, not 0xBEEF.
- Full, wr_en=rd_en=1 → standard mode: data_out=0x0001 next cycle, overflow=1, count=7. Empty, both asserted → underflow=1, wr_ack=1, count=1.
- Pointer wrap: do 20 alternating write/read pairs with incrementing data → every read matches its write in order. count toggles 1/0 and never exceeds 1.
- With count=5, assert clr together with wr_en and rd_en → count=0, empty=1, wr_ack=0, underflow=0. In standard mode data_out is unchanged.
- With SYNC_FIFO_FWFT_EN defined: write 0x00AA into an empty FIFO → data_out=0x00AA right after that edge, with no rd_en. rd_en=1 for one cycle → data_out=0, empty=1.

Source files
------------

// File: rtl/sync_fifo_v2.sv
// -----------------------------------------------------------------------------
// sync_fifo_v2
//
// Parametrised single-clock FIFO that sits between a producer and a consumer in
// the same clock domain. It provides:
//   - configurable almost-full / almost-empty thresholds
//   - an occupancy count output
//   - a synchronous flush (clr)
//   - an optional first-word-fall-through read mode
//
// Optional feature macro:
//   SYNC_FIFO_FWFT_EN  - when defined, data_out is the head word, driven
//                        combinationally (0 while empty). When undefined,
//                        data_out is a register loaded on each accepted read.
//
// Parameters:
//   DATA_WIDTH - width of each stored word
//   DEPTH      - number of entries (power of two, >= 4)
//   AF_THRESH  - almostfull  = (count >= AF_THRESH), 1 <= AF_THRESH < DEPTH
//   AE_THRESH  - almostempty = (count <= AE_THRESH), 0 <  AE_THRESH < DEPTH
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous flush; takes priority over wr_en and rd_en
//   wr_en       in   write request
//   data_in     in   write data
//   rd_en       in   read request
//   data_out    out  read data (registered, or head word in FWFT mode)
//   wr_ack      out  registered: previous cycle's write was accepted
//   overflow    out  registered: previous cycle's write was rejected (full)
//   underflow   out  registered: previous cycle's read was rejected (empty)
//   full        out  count == DEPTH
//   empty       out  count == 0
//   almostfull  out  count >= AF_THRESH
//   almostempty out  count <= AE_THRESH
//   count       out  current occupancy, 0..DEPTH
//
// Handshake:
//   A request is a single-cycle assertion of wr_en / rd_en sampled at the
//   rising edge. There is no back-pressure stall: a write while full or a read
//   while empty is dropped, and the outcome is reported one cycle later on
//   wr_ack / overflow / underflow. Acceptance is judged against full/empty as
//   they stand at the start of the cycle, so a simultaneous read+write on a
//   full FIFO drops the write and one on an empty FIFO drops the read. While
//   clr is high, no request is accepted and no response pulse is produced.
// -----------------------------------------------------------------------------
module sync_fifo_v2 #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic                        wr_en,
   input  logic [DATA_WIDTH-1:0]       data_in,
   input  logic                        rd_en,
   output logic [DATA_WIDTH-1:0]       data_out,
   output logic                        wr_ack,
   output logic                        overflow,
   output logic                        underflow,
   output logic                        full,
   output logic                        empty,
   output logic                        almostfull,
   output logic                        almostempty,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Typed constants keep every compare and increment at matching widths.
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C      = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C      = CW'(AE_THRESH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         cnt;

   logic                  wr_acc;
   logic                  rd_acc;
   logic [CW-1:0]         cnt_next;

   // ---------------------------------------------------------------------------
   // Status flags, decoded from the count register only
   // ---------------------------------------------------------------------------
   always_comb begin
      full        = (cnt == DEPTH_C);
      empty       = (cnt == '0);
      almostfull  = (cnt >= AF_C);
      almostempty = (cnt <= AE_C);
      count       = cnt;
   end

   // ---------------------------------------------------------------------------
   // Accept decisions. Flush wins over both requests.
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_acc = wr_en & ~full  & ~clr;
      rd_acc = rd_en & ~empty & ~clr;
   end

   always_comb begin
      cnt_next = cnt;
      case ({wr_acc, rd_acc})
         2'b10:   cnt_next = cnt + CNT_ONE;
         2'b01:   cnt_next = cnt - CNT_ONE;
         default: cnt_next = cnt;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Pointers and occupancy. Pointers are exactly AW bits wide and wrap from
   // DEPTH-1 to 0 on their own because DEPTH is a power of two.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         cnt <= cnt_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Storage. Contents are never cleared; reset and flush only move the
   // pointers, so stale words are unreachable rather than erased.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= data_in;
   end

   // ---------------------------------------------------------------------------
   // Response pulses. Each one reflects only the request of the cycle just
   // ended, so a held request yields a pulse on every cycle it is rejected.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ack    <= wr_acc;
         overflow  <= wr_en & full  & ~clr;
         underflow <= rd_en & empty & ~clr;
      end
   end

   // ---------------------------------------------------------------------------
   // Read data path
   // ---------------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN
   // Head word is visible as soon as the FIFO is non-empty. A read and a write
   // in the same cycle never touch the same slot (the read needs !empty, the
   // write needs !full), so no bypass from data_in is required.
   always_comb begin
      data_out = empty ? '0 : mem[rd_ptr];
   end
`else
   // Registered read: loads the head word on an accepted read and otherwise
   // holds, including across a flush.
   logic [DATA_WIDTH-1:0] data_out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q <= '0;
      end else if (rd_acc) begin
         data_out_q <= mem[rd_ptr];
      end
   end

   always_comb begin
      data_out = data_out_q;
   end
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_v2
//
// Self-checking bench for sync_fifo_v2 at the default configuration
// (DATA_WIDTH=16, DEPTH=8, AF_THRESH=7, AE_THRESH=1). A queue-based reference
// model tracks the FIFO contents and the response pulses; every step compares
// all DUT outputs against it. A directed table of hand-derived vectors covers
// the fill/overflow/drain/underflow/flush corners, followed by a pointer-wrap
// sequence, randomized traffic and a mid-operation asynchronous reset.
// -----------------------------------------------------------------------------
module tb_sync_fifo_v2;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int CW    = 4;
   localparam int AF    = DEPTH - 1;
   localparam int AE    = 1;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          wr_ack;
   logic          overflow;
   logic          underflow;
   logic          full;
   logic          empty;
   logic          almostfull;
   logic          almostempty;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   sync_fifo_v2 #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_THRESH  (AF),
      .AE_THRESH  (AE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .wr_en       (wr_en),
      .data_in     (data_in),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .wr_ack      (wr_ack),
      .overflow    (overflow),
      .underflow   (underflow),
      .full        (full),
      .empty       (empty),
      .almostfull  (almostfull),
      .almostempty (almostempty),
      .count       (count)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard / reference model
   // ---------------------------------------------------------------------------
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   logic          m_ack;
   logic          m_ovf;
   logic          m_udf;
   logic [DW-1:0] m_dout;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      int n;
      n = exp_q.size();
      check("count",       32'(count),       32'(n));
      check("full",        32'(full),        32'(n == DEPTH));
      check("empty",       32'(empty),       32'(n == 0));
      check("almostfull",  32'(almostfull),  32'(n >= AF));
      check("almostempty", 32'(almostempty), 32'(n <= AE));
      check("wr_ack",      32'(wr_ack),      32'(m_ack));
      check("overflow",    32'(overflow),    32'(m_ovf));
      check("underflow",   32'(underflow),   32'(m_udf));
      check("data_out",    32'(data_out),    32'(m_dout));
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ack  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
   endtask

   // ---------------------------------------------------------------------------
   // Driver: apply one cycle of inputs, advance the model, compare at edge+1.
   // ---------------------------------------------------------------------------
   task automatic step(input bit c, input bit w, input bit r, input logic [DW-1:0] d);
      bit was_full;
      bit was_empty;
      bit wa;
      bit ra;
      clr      = c;
      wr_en    = w;
      rd_en    = r;
      data_in  = d;
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      wa = w && !was_full  && !c;
      ra = r && !was_empty && !c;
      @(posedge clk);
      if (c) begin
         exp_q.delete();
         m_ack = 1'b0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         m_ack = wa;
         m_ovf = w && was_full;
         m_udf = r && was_empty;
         if (ra) begin
`ifdef SYNC_FIFO_FWFT_EN
            void'(exp_q.pop_front());
`else
            m_dout = exp_q.pop_front();
`endif
         end
         if (wa) exp_q.push_back(d);
      end
`ifdef SYNC_FIFO_FWFT_EN
      m_dout = (exp_q.size() != 0) ? exp_q[0] : '0;
`endif
      #1;
      compare_model();
   endtask

   // ---------------------------------------------------------------------------
   // Directed vector table (expected values derived by hand)
   // ---------------------------------------------------------------------------
   typedef struct {
      bit            c;
      bit            w;
      bit            r;
      logic [DW-1:0] d;
      int            e_cnt;
      bit            e_ack;
      bit            e_ovf;
      bit            e_udf;
      logic [DW-1:0] e_dout;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input bit c, input bit w, input bit r, input logic [DW-1:0] d,
                          input int e_cnt, input bit e_ack, input bit e_ovf, input bit e_udf,
                          input logic [DW-1:0] e_dout);
      vec_t v;
      v.c = c; v.w = w; v.r = r; v.d = d;
      v.e_cnt = e_cnt; v.e_ack = e_ack; v.e_ovf = e_ovf; v.e_udf = e_udf; v.e_dout = e_dout;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] v16;
      int            fill_bias;

      // Fill 0x0001..0x0008, almostfull at 7, full at 8
      for (int i = 0; i < 8; i++) add_vec(0, 1, 0, DW'(i + 1), i + 1, 1, 0, 0, 16'h0000);
      add_vec(0, 1, 0, 16'hBEEF, 8, 0, 1, 0, 16'h0000);   // write while full
      add_vec(0, 0, 0, 16'h0000, 8, 0, 0, 0, 16'h0000);   // overflow is one pulse
      add_vec(0, 1, 1, 16'h00CC, 7, 0, 1, 0, 16'h0001);   // full, wr+rd
      for (int i = 0; i < 7; i++) add_vec(0, 0, 1, 16'h0000, 6 - i, 0, 0, 0, DW'(i + 2));
      add_vec(0, 0, 1, 16'h0000, 0, 0, 0, 1, 16'h0008);   // read while empty
      add_vec(0, 1, 1, 16'h0055, 1, 1, 0, 1, 16'h0008);   // empty, wr+rd
      for (int i = 0; i < 4; i++) add_vec(0, 1, 0, DW'(16'h0010 + i), i + 2, 1, 0, 0, 16'h0008);
      add_vec(1, 1, 1, 16'h7777, 0, 0, 0, 0, 16'h0008);   // flush at count 5
      add_vec(0, 0, 1, 16'h0000, 0, 0, 0, 1, 16'h0008);   // flushed FIFO reads as empty

      // Reset
      rst_n   = 1'b0;
      clr     = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;
      model_reset();
      #12;
      compare_model();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table
      foreach (vecs[i]) begin
         step(vecs[i].c, vecs[i].w, vecs[i].r, vecs[i].d);
         check($sformatf("vec%0d_count", i),     32'(count),     32'(vecs[i].e_cnt));
         check($sformatf("vec%0d_wr_ack", i),    32'(wr_ack),    32'(vecs[i].e_ack));
         check($sformatf("vec%0d_overflow", i),  32'(overflow),  32'(vecs[i].e_ovf));
         check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].e_udf));
`ifndef SYNC_FIFO_FWFT_EN
         check($sformatf("vec%0d_data_out", i),  32'(data_out),  32'(vecs[i].e_dout));
`endif
      end

`ifdef SYNC_FIFO_FWFT_EN
      // Head word appears right after the write edge with no read
      step(0, 1, 0, 16'h00AA);
      check("fwft_head", 32'(data_out), 32'h00AA);
      step(0, 0, 1, 16'h0000);
      check("fwft_pop_data", 32'(data_out), 32'h0000);
      check("fwft_pop_empty", 32'(empty), 32'h1);
`endif

      // Pointer wrap: alternating write/read pairs, data ordering via model
      for (int k = 0; k < 20; k++) begin
         v16 = DW'(16'h0100 + k);
         step(0, 1, 0, v16);
         check("wrap_count_max", 32'(count <= 1), 32'h1);
         step(0, 0, 1, 16'h0000);
`ifndef SYNC_FIFO_FWFT_EN
         check("wrap_data", 32'(data_out), 32'(v16));
`endif
      end

      // Randomized traffic, biased to alternately fill and drain
      for (int k = 0; k < 800; k++) begin
         fill_bias = ((k / 50) % 2 == 0) ? 3 : 1;
         step($urandom_range(0, 63) == 0,
              $urandom_range(0, 3) < fill_bias,
              $urandom_range(0, 3) >= fill_bias,
              DW'($urandom));
      end

      // Asynchronous reset mid-operation
      for (int k = 0; k < 5; k++) step(0, 1, 0, DW'(16'h0A00 + k));
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_model();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 1, 16'h0000);                    // first edge: behaves as empty
      step(0, 1, 0, 16'h0C01);
      step(0, 0, 1, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
